// File: rtl/hazard_ctrl.sv
// hazard_ctrl: decode-stage hazard detection, long-latency scoreboard and
// redirect flush sequencing.
// Optional feature macro: HAZARD_STALL_STATS_EN enables the saturating
// stall_cnt counter. When it is undefined, stall_cnt is tied to zero.
module hazard_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dec_valid,
  input  logic [4:0]  dec_rs1,
  input  logic [4:0]  dec_rs2,
  input  logic        dec_use_rs1,
  input  logic        dec_use_rs2,
  input  logic [4:0]  dec_rd,
  input  logic        dec_wr,
  input  logic        dec_long,
  input  logic        redirect,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  output logic        stall,
  output logic        flush_if,
  output logic        flush_dec,
  output logic        issue,
  output logic [31:0] sb_pending,
  output logic [31:0] stall_cnt
);

  typedef enum logic {RUN, FLUSH} state_t;

  // Counter value loaded on redirect: the redirect cycle itself is the first
  // flush cycle, and FLUSH exits one cycle after the counter reaches zero.
  localparam logic [3:0] RELOAD =
    (FLUSH_CYCLES > 1) ? 4'(FLUSH_CYCLES - 2) : 4'd0;
  localparam bit MULTI_CYCLE = (FLUSH_CYCLES > 1);

  state_t      state;
  logic [3:0]  flush_cnt;
  logic [31:0] sb_q;
  logic        rs1_haz, rs2_haz, waw_haz, any_haz;
  logic [31:0] sb_set, sb_clr;

  assign sb_pending = sb_q;

  // Hazard detection; a same-cycle writeback resolves the dependency.
  always_comb begin
    rs1_haz = dec_use_rs1 && (dec_rs1 != '0) && sb_q[dec_rs1] &&
              !(wb_valid && (wb_rd == dec_rs1));
    rs2_haz = dec_use_rs2 && (dec_rs2 != '0) && sb_q[dec_rs2] &&
              !(wb_valid && (wb_rd == dec_rs2));
    waw_haz = dec_wr && (dec_rd != '0) && sb_q[dec_rd] &&
              !(wb_valid && (wb_rd == dec_rd));
    any_haz = rs1_haz || rs2_haz || waw_haz;
  end

  // Pipeline control outputs derived from current state and inputs.
  always_comb begin
    flush_if  = redirect || (state == FLUSH);
    flush_dec = flush_if;
    stall     = dec_valid && any_haz && (state == RUN) && !redirect;
    issue     = dec_valid && !stall && !flush_dec;
  end

  // Scoreboard set/clear masks for this cycle.
  always_comb begin
    sb_set = '0;
    sb_clr = '0;
    if (issue && dec_long && dec_wr && (dec_rd != '0))
      sb_set[dec_rd] = 1'b1;
    if (wb_valid && (wb_rd != '0))
      sb_clr[wb_rd] = 1'b1;
  end

  // Scoreboard register; set wins over clear, bit 0 never set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      sb_q <= '0;
    else
      sb_q <= {((sb_q[31:1] & ~sb_clr[31:1]) | sb_set[31:1]), 1'b0};
  end

  // RUN/FLUSH sequencer with down-counter; redirect in FLUSH reloads it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= RUN;
      flush_cnt <= '0;
    end else begin
      case (state)
        RUN: begin
          if (redirect && MULTI_CYCLE) begin
            state     <= FLUSH;
            flush_cnt <= RELOAD;
          end
        end
        FLUSH: begin
          if (redirect) begin
            flush_cnt <= RELOAD;
          end else if (flush_cnt == '0) begin
            state <= RUN;
          end else begin
            flush_cnt <= flush_cnt - 4'd1;
          end
        end
        default: begin
          state     <= RUN;
          flush_cnt <= '0;
        end
      endcase
    end
  end

`ifdef HAZARD_STALL_STATS_EN
  logic [31:0] stall_cnt_q;

  // Saturating count of stalled cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      stall_cnt_q <= '0;
    else if (stall && (stall_cnt_q != '1))
      stall_cnt_q <= stall_cnt_q + 32'd1;
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule
